// File: rtl/sgmii_link_ctrl.sv
// sgmii_link_ctrl: SGMII PCS/PMA bring-up and link supervision sequencer
`timescale 1ns/1ps
module sgmii_link_ctrl #(
  parameter int RST_CYCLES    = 16,
  parameter int AN_TIMEOUT    = 1000000,
  parameter int LINK_DEBOUNCE = 1024
) (
  input  logic        S_AXI_ACLK,
  input  logic        S_AXI_ARESETN,
  input  logic        enable,
  input  logic        restart,
  input  logic        mcmm_locked,
  input  logic [15:0] status_vector,
  input  logic [4:0]  cfg_vector_in,
  input  logic [15:0] an_adv_in,
  output logic        sgmii_reset,
  output logic        signal_detect,
  output logic [4:0]  configuration_vector,
  output logic        configuration_valid,
  output logic [15:0] an_adv_config_vector,
  output logic        an_adv_config_val,
  output logic        an_restart_config,
  output logic [2:0]  state,
  output logic        link_up,
  output logic [7:0]  retry_cnt
);
  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    RESET     = 3'd1,
    WAIT_LOCK = 3'd2,
    CONFIG    = 3'd3,
    AN_WAIT   = 3'd4,
    LINK_UP   = 3'd5
  } state_e;
  localparam logic [31:0] RST_LAST = 32'(RST_CYCLES - 1);
  localparam logic [31:0] TMO_LAST = 32'(AN_TIMEOUT - 1);
  localparam logic [15:0] DEB_LAST = 16'(LINK_DEBOUNCE - 1);
  state_e      state_q, state_d, norm;
  logic [31:0] cnt_q, cnt_d;
  logic [15:0] deb_q, deb_d;
  logic [7:0]  retry_q, retry_d;
  logic [4:0]  cfg_q, cfg_d;
  logic [15:0] adv_q, adv_d;
  logic        pulse_q, pulse_d;
  logic        an_rst_q, an_rst_d;
  logic        sreset_q, sreset_d;
  logic        sdet_q, sdet_d;
  logic        lnk_q, lnk_d;
  logic        link, link_ok, tmo, active, force_idle, force_rst, force_lock, normal, enter, bump;
  logic        unused_status;
  assign unused_status = ^status_vector[15:1];
  assign link = status_vector[0];
  // Next state with global overrides, counters and registered output values
  always_comb begin
    link_ok = link && deb_q == DEB_LAST;
    tmo = cnt_q == TMO_LAST;
    norm = state_q;
    case (state_q)
      IDLE:      norm = enable ? RESET : IDLE;
      RESET:     norm = cnt_q == RST_LAST ? WAIT_LOCK : RESET;
      WAIT_LOCK: norm = mcmm_locked ? CONFIG : WAIT_LOCK;
      CONFIG:    norm = cnt_q == 32'd1 ? AN_WAIT : CONFIG;
      AN_WAIT:   norm = link_ok ? LINK_UP : tmo ? RESET : AN_WAIT;
      LINK_UP:   norm = link ? LINK_UP : CONFIG;
      default:   norm = IDLE;
    endcase
    active = state_q inside {CONFIG, AN_WAIT, LINK_UP};
    force_idle = !enable || state_q > LINK_UP;
    force_rst = restart && state_q != IDLE;
    force_lock = !mcmm_locked && active;
    normal = !(force_idle || force_rst || force_lock);
    state_d = force_idle ? IDLE : force_rst ? RESET : force_lock ? WAIT_LOCK : norm;
    enter = state_d != state_q || (force_rst && !force_idle);
    bump = normal && state_q == AN_WAIT && !link_ok && tmo;
    cnt_d = enter ? 32'd0 : cnt_q + 32'd1;
    deb_d = enter || !link ? 16'd0 : deb_q + 16'd1;
    retry_d = retry_q + 8'(bump && retry_q != 8'hff);
    pulse_d = enter && state_d == CONFIG;
    an_rst_d = !enter && state_q == CONFIG && state_d == CONFIG;
    cfg_d = pulse_d ? cfg_vector_in : cfg_q;
    adv_d = pulse_d ? an_adv_in : adv_q;
    sreset_d = !(state_d inside {CONFIG, AN_WAIT, LINK_UP});
    sdet_d = !sreset_d;
    lnk_d = state_d == LINK_UP;
  end
  // State, counters and all outputs share one register stage
  always_ff @(posedge S_AXI_ACLK) begin
    if (!S_AXI_ARESETN) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      deb_q    <= '0;
      retry_q  <= '0;
      cfg_q    <= '0;
      adv_q    <= '0;
      pulse_q  <= 1'b0;
      an_rst_q <= 1'b0;
      sreset_q <= 1'b1;
      sdet_q   <= 1'b0;
      lnk_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      deb_q    <= deb_d;
      retry_q  <= retry_d;
      cfg_q    <= cfg_d;
      adv_q    <= adv_d;
      pulse_q  <= pulse_d;
      an_rst_q <= an_rst_d;
      sreset_q <= sreset_d;
      sdet_q   <= sdet_d;
      lnk_q    <= lnk_d;
    end
  end
  assign state = state_q;
  assign sgmii_reset = sreset_q;
  assign signal_detect = sdet_q;
  assign configuration_vector = cfg_q;
  assign configuration_valid = pulse_q;
  assign an_adv_config_vector = adv_q;
  assign an_adv_config_val = pulse_q;
  assign an_restart_config = an_rst_q;
  assign link_up = lnk_q;
  assign retry_cnt = retry_q;
endmodule

// File: tb/tb_sgmii_link_ctrl.sv
// tb_sgmii_link_ctrl: vector table plus directed sequences for sgmii_link_ctrl
`timescale 1ns/1ps
module tb_sgmii_link_ctrl;
  localparam int RST = 4, TMO = 100, DEB = 8;
  localparam int PERIOD = RST + 1 + 2 + TMO;
  typedef struct {
    logic       en;
    logic       rs;
    logic       lock;
    logic       link;
    logic [8:0] exp;
  } vec_t;
  logic        clk = 1'b0;
  logic        rstn, en, rs, lock, link;
  logic [4:0]  cfg;
  logic [15:0] adv;
  logic        sreset, sdet, cval, aval, arst, lu;
  logic [4:0]  cfg_o;
  logic [15:0] adv_o;
  logic [2:0]  st;
  logic [7:0]  retry;
  logic [8:0]  obs;
  int          checks = 0, errors = 0;
  vec_t        vt[17];
  vec_t        sbq[$];
  always #5 clk = ~clk;
  sgmii_link_ctrl #(.RST_CYCLES(RST), .AN_TIMEOUT(TMO), .LINK_DEBOUNCE(DEB)) dut (
    .S_AXI_ACLK(clk),
    .S_AXI_ARESETN(rstn),
    .enable(en),
    .restart(rs),
    .mcmm_locked(lock),
    .status_vector({15'h0, link}),
    .cfg_vector_in(cfg),
    .an_adv_in(adv),
    .sgmii_reset(sreset),
    .signal_detect(sdet),
    .configuration_vector(cfg_o),
    .configuration_valid(cval),
    .an_adv_config_vector(adv_o),
    .an_adv_config_val(aval),
    .an_restart_config(arst),
    .state(st),
    .link_up(lu),
    .retry_cnt(retry)
  );
  assign obs = {st, sreset, sdet, cval, aval, arst, lu};
  function automatic logic [8:0] ex(int s, bit cv, bit ar);
    logic [2:0] s3;
    s3 = 3'(s);
    return {s3, s3 < 3'd3, s3 >= 3'd3, cv, cv, ar, s3 == 3'd5};
  endfunction
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask
  task automatic run_vec(vec_t v, int idx);
    vec_t e;
    en = v.en;
    rs = v.rs;
    lock = v.lock;
    link = v.link;
    sbq.push_back(v);
    tick();
    e = sbq.pop_front();
    chk($sformatf("vec%0d", idx), 32'(obs), 32'(e.exp));
  endtask
  task automatic wait_inc(output int n);
    logic [7:0] r0;
    r0 = retry;
    n = 0;
    while (retry == r0 && n < 1000) begin
      tick();
      n++;
    end
  endtask
  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end
  initial begin
    int  n;
    bit  saw_lu;
    for (int c = 1; c <= 17; c++) begin
      int s;
      s = c <= 4 ? 1 : c == 5 ? 2 : c <= 7 ? 3 : c <= 15 ? 4 : 5;
      vt[c-1] = '{en: 1'b1, rs: 1'b0, lock: 1'b1, link: 1'b1, exp: ex(s, c == 6, c == 7)};
    end
    rstn = 1'b0; en = 1'b1; rs = 1'b0; lock = 1'b1; link = 1'b1;
    cfg = 5'h10; adv = 16'h0001;
    repeat (3) tick();
    chk("reset_obs", 32'(obs), 32'(ex(0, 0, 0)));
    chk("reset_cfg", 32'(cfg_o), 0);
    chk("reset_adv", 32'(adv_o), 0);
    chk("reset_retry", 32'(retry), 0);
    en = 1'b0;
    rstn = 1'b1;
    tick();
    chk("idle_hold", 32'(obs), 32'(ex(0, 0, 0)));
    for (int i = 0; i < 17; i++) run_vec(vt[i], i);
    chk("latch_cfg", 32'(cfg_o), 32'h10);
    chk("latch_adv", 32'(adv_o), 32'h0001);
    cfg = 5'h0A; adv = 16'hBEEF;
    repeat (5) tick();
    chk("hold_state", 32'(st), 5);
    chk("hold_cfg", 32'(cfg_o), 32'h10);
    chk("hold_adv", 32'(adv_o), 32'h0001);
    link = 1'b0;
    tick();
    chk("drop_config", 32'(obs), 32'(ex(3, 1, 0)));
    chk("relatch_cfg", 32'(cfg_o), 32'h0A);
    chk("relatch_adv", 32'(adv_o), 32'hBEEF);
    link = 1'b1;
    tick();
    chk("drop_restart", 32'(obs), 32'(ex(3, 0, 1)));
    repeat (DEB) tick();
    chk("dwell_last", 32'(st), 4);
    tick();
    chk("dwell_up", 32'(obs), 32'(ex(5, 0, 0)));
    chk("dwell_retry", 32'(retry), 0);
    lock = 1'b0;
    tick();
    chk("lock_drop", 32'(obs), 32'(ex(2, 0, 0)));
    tick();
    chk("lock_wait", 32'(st), 2);
    lock = 1'b1;
    tick();
    chk("lock_cfg", 32'(obs), 32'(ex(3, 1, 0)));
    tick();
    chk("lock_restart", 32'(obs), 32'(ex(3, 0, 1)));
    link = 1'b0;
    tick();
    for (int j = 0; j < TMO; j++) begin
      link = j >= TMO - DEB;
      tick();
      if (j == TMO - 2) chk("tie_before", 32'(st), 4);
      if (j == TMO - 1) chk("tie_linkup", 32'(st), 5);
    end
    chk("tie_retry", 32'(retry), 0);
    link = 1'b0;
    repeat (3) tick();
    chk("toggle_entry", 32'(st), 4);
    saw_lu = 1'b0;
    for (int j = 0; j < TMO; j++) begin
      link = j % 8 != 7;
      tick();
      saw_lu |= lu;
      if (j == TMO - 2) chk("toggle_before", 32'(st), 4);
      if (j == TMO - 1) chk("toggle_timeout", 32'(st), 1);
    end
    chk("toggle_no_lu", 32'(saw_lu), 0);
    chk("toggle_retry", 32'(retry), 1);
    link = 1'b0;
    wait_inc(n);
    chk("period1", n, PERIOD);
    chk("retry2", 32'(retry), 2);
    wait_inc(n);
    chk("period2", n, PERIOD);
    repeat (297 * PERIOD + 10) tick();
    chk("retry_sat", 32'(retry), 255);
    en = 1'b0; rs = 1'b1;
    tick();
    chk("restart_disable", 32'(obs), 32'(ex(0, 0, 0)));
    tick();
    chk("restart_idle", 32'(st), 0);
    rs = 1'b0; en = 1'b1;
    tick();
    repeat (7) tick();
    chk("restart_pre", 32'(st), 4);
    rs = 1'b1;
    tick();
    rs = 1'b0;
    chk("restart_reset", 32'(obs), 32'(ex(1, 0, 0)));
    repeat (RST - 1) tick();
    chk("restart_hold", 32'(st), 1);
    tick();
    chk("restart_wl", 32'(st), 2);
    tick();
    chk("pulse_cfg", 32'(obs), 32'(ex(3, 1, 0)));
    rstn = 1'b0;
    tick();
    chk("abort_obs", 32'(obs), 32'(ex(0, 0, 0)));
    chk("abort_cfg", 32'(cfg_o), 0);
    chk("abort_adv", 32'(adv_o), 0);
    chk("abort_retry", 32'(retry), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
